// File: rtl/btn_pkg.sv
// Shared types and default timing for the push-button conditioner.
// Repeat-FSM encoding is fixed so the unused code 2'd3 recovers to idle.
package btn_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StDelay  = 2'd1,
        StRepeat = 2'd2,
        StRsvd   = 2'd3
    } rpt_state_e;

    localparam int unsigned DefNBtn        = 7;
    localparam int unsigned DefSampleDiv   = 100000;
    localparam int unsigned DefDbLen       = 4;
    localparam int unsigned DefRepeatDelay = 500;
    localparam int unsigned DefRepeatRate  = 100;
    localparam logic [6:0]  DefRepeatMask  = 7'b0011000;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/btn_lane.sv
// One button lane: 2-flop synchronizer, tick-sampled debounce, press pulse and
// optional hold-to-repeat FSM. All outputs are registered.
module btn_lane
    import btn_pkg::*;
#(
    parameter int unsigned DB_LEN       = DefDbLen,
    parameter int unsigned REPEAT_DELAY = DefRepeatDelay,
    parameter int unsigned REPEAT_RATE  = DefRepeatRate,
    parameter bit          REPEAT_EN    = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_i,
    input  logic raw_i,
    output logic level_o,
    output logic pulse_o
);

    localparam int unsigned RcntW = cnt_width(max_u(REPEAT_DELAY, REPEAT_RATE));
    localparam logic [RcntW-1:0] DelayLast = RcntW'(REPEAT_DELAY - 1);
    localparam logic [RcntW-1:0] RateLast  = RcntW'(REPEAT_RATE - 1);

    if (DB_LEN < 2) begin : g_bad_db_len
        $error("btn_lane: DB_LEN must be at least 2");
    end
    if (REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_repeat
        $error("btn_lane: REPEAT_DELAY and REPEAT_RATE must be at least 1");
    end

    logic                sync1_q, sync2_q;
    // Only the older DB_LEN-1 samples are stored; the newest is sync2_q itself.
    logic [DB_LEN-2:0]   hist_q, hist_d;
    logic [DB_LEN-1:0]   window;
    logic                level_q, level_d;
    logic                rise, fall;
    logic                pulse_q;
    rpt_state_e          state_q;
    logic [RcntW-1:0]    rcnt_q;

    always_comb begin
        window  = {hist_q, sync2_q};
        hist_d  = hist_q;
        level_d = level_q;
        if (tick_i) begin
            hist_d = window[DB_LEN-2:0];
            if (&window) begin
                level_d = 1'b1;
            end else if (~|window) begin
                level_d = 1'b0;
            end
        end
        rise = level_d & ~level_q;
        fall = ~level_d & level_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= '0;
            level_q <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            hist_q  <= hist_d;
            level_q <= level_d;
        end
    end

    // Repeat FSM; the pulse register is shared with the press pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            rcnt_q  <= '0;
            pulse_q <= 1'b0;
        end else begin
            pulse_q <= rise;
            if (!REPEAT_EN || fall) begin
                // A release wins over a coincident repeat threshold.
                state_q <= StIdle;
                rcnt_q  <= '0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (rise) begin
                            state_q <= StDelay;
                            rcnt_q  <= '0;
                        end
                    end
                    StDelay: begin
                        if (tick_i) begin
                            if (rcnt_q == DelayLast) begin
                                pulse_q <= 1'b1;
                                state_q <= StRepeat;
                                rcnt_q  <= '0;
                            end else begin
                                rcnt_q <= rcnt_q + 1'b1;
                            end
                        end
                    end
                    StRepeat: begin
                        if (tick_i) begin
                            if (rcnt_q == RateLast) begin
                                pulse_q <= 1'b1;
                                rcnt_q  <= '0;
                            end else begin
                                rcnt_q <= rcnt_q + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                        rcnt_q  <= '0;
                    end
                endcase
            end
        end
    end

    assign level_o = level_q;
    assign pulse_o = pulse_q;

endmodule

// File: rtl/btn_conditioner.sv
// Push-button input conditioning: shared debounce sample tick plus one
// independent btn_lane per button.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int unsigned       N_BTN        = DefNBtn,
    parameter int unsigned       SAMPLE_DIV   = DefSampleDiv,
    parameter int unsigned       DB_LEN       = DefDbLen,
    parameter logic [N_BTN-1:0]  REPEAT_MASK  = N_BTN'(DefRepeatMask),
    parameter int unsigned       REPEAT_DELAY = DefRepeatDelay,
    parameter int unsigned       REPEAT_RATE  = DefRepeatRate
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_pulse
);

    localparam int unsigned TickW = cnt_width(SAMPLE_DIV);
    localparam logic [TickW-1:0] TickLast = TickW'(SAMPLE_DIV - 1);

    if (SAMPLE_DIV < 2) begin : g_bad_sample_div
        $error("btn_conditioner: SAMPLE_DIV must be at least 2");
    end

    logic [TickW-1:0] tcnt_q, tcnt_d;
    logic             tick;

    always_comb begin
        tick   = (tcnt_q == TickLast);
        tcnt_d = tick ? '0 : tcnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tcnt_q <= '0;
        end else begin
            tcnt_q <= tcnt_d;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_lane
        btn_lane #(
            .DB_LEN       (DB_LEN),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_RATE  (REPEAT_RATE),
            .REPEAT_EN    (REPEAT_MASK[i])
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .tick_i  (tick),
            .raw_i   (btn_raw[i]),
            .level_o (btn_level[i]),
            .pulse_o (btn_pulse[i])
        );
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Randomized bench for btn_conditioner, checked every cycle against a
// tick-count based reference model of debounce, press and repeat behaviour.
module tb_btn_conditioner;

    localparam int N  = 7;
    localparam int SD = 4;
    localparam int DB = 4;
    localparam int RD = 5;
    localparam int RR = 2;
    localparam logic [N-1:0] MASK = 7'b0011000;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] btn_raw;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_pulse;

    always #5 clk = ~clk;

    btn_conditioner #(
        .N_BTN        (N),
        .SAMPLE_DIV   (SD),
        .DB_LEN       (DB),
        .REPEAT_MASK  (MASK),
        .REPEAT_DELAY (RD),
        .REPEAT_RATE  (RR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (btn_raw),
        .btn_level (btn_level),
        .btn_pulse (btn_pulse)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Reference model: sampled value seen two edges after the raw input, level follows
    // a run of DB equal samples, repeats fall at fixed tick distances from the press.
    int           raw_d1 [N];
    int           raw_d2 [N];
    int           run_val[N];
    int           run_len[N];
    int           press_tick[N];
    logic [N-1:0] exp_level;
    logic [N-1:0] exp_pulse;
    int           edges_since_rst;
    int           tick_num;

    task automatic model_edge(input logic r, input logic [N-1:0] raw);
        bit tick;
        int new_lvl;
        int d;
        if (!r) begin
            for (int l = 0; l < N; l++) begin
                raw_d1[l]     = 0;
                raw_d2[l]     = 0;
                run_val[l]    = 0;
                run_len[l]    = DB;
                press_tick[l] = 0;
            end
            exp_level       = '0;
            exp_pulse       = '0;
            edges_since_rst = 0;
            tick_num        = 0;
        end else begin
            tick = ((edges_since_rst % SD) == SD - 1);
            edges_since_rst++;
            if (tick) tick_num++;
            for (int l = 0; l < N; l++) begin
                exp_pulse[l] = 1'b0;
                if (tick) begin
                    if (raw_d2[l] == run_val[l]) begin
                        if (run_len[l] < DB) run_len[l]++;
                    end else begin
                        run_val[l] = raw_d2[l];
                        run_len[l] = 1;
                    end
                    new_lvl = (run_len[l] >= DB) ? run_val[l] : int'(exp_level[l]);
                    if (new_lvl == 1 && !exp_level[l]) begin
                        exp_pulse[l]  = 1'b1;
                        press_tick[l] = tick_num;
                    end else if (new_lvl == 1 && exp_level[l] && MASK[l]) begin
                        d = tick_num - press_tick[l];
                        if (d == RD || (d > RD && ((d - RD) % RR) == 0)) exp_pulse[l] = 1'b1;
                    end
                    exp_level[l] = (new_lvl == 1);
                end
                raw_d2[l] = raw_d1[l];
                raw_d1[l] = int'(raw[l]);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(rst, btn_raw);
        #1;
        check_eq("btn_level", 32'(btn_level), 32'(exp_level));
        check_eq("btn_pulse", 32'(btn_pulse), 32'(exp_pulse));
    endtask

    int hold_left[N];
    int rst_left;

    initial begin
        rst     = 1'b0;
        btn_raw = '1;
        repeat (3) step();
        rst = 1'b1;
        // All buttons held through reset: fresh presses, repeats on masked lanes.
        repeat (160) step();

        for (int l = 0; l < N; l++) hold_left[l] = $urandom_range(0, 40);
        rst_left = 0;
        for (int c = 0; c < 9000; c++) begin
            for (int l = 0; l < N; l++) begin
                if (hold_left[l] == 0) begin
                    btn_raw[l] = ~btn_raw[l];
                    if ($urandom_range(0, 99) < 35) hold_left[l] = $urandom_range(1, 3);
                    else hold_left[l] = $urandom_range(10, 140);
                end else begin
                    hold_left[l]--;
                end
            end
            if (rst_left > 0) begin
                rst = 1'b0;
                rst_left--;
            end else if ($urandom_range(0, 999) == 0) begin
                rst      = 1'b0;
                rst_left = $urandom_range(0, 2);
            end else begin
                rst = 1'b1;
            end
            step();
        end

        rst     = 1'b1;
        btn_raw = '0;
        repeat (40) step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
